// File: rtl/x_ctrl_seq.sv
// x_ctrl_seq: execute-stage control; decodes the X-stage instruction, sequences the multdiv unit,
// flushes after taken branches and writes exception codes to rstatus. Macro X_CTRL_PERF_EN adds perf counters.
module x_ctrl_seq #(
    parameter int WORD_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int MD_TIMEOUT   = 40,
    parameter int RSTATUS_MUL  = 4,
    parameter int RSTATUS_DIV  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [4:0]        opcode,
    input  logic [4:0]        aluop,
    input  logic              isNotEqual,
    input  logic              isLessThan,
    input  logic              md_ready,
    input  logic              md_exception,
    output logic              reg_wren,
    output logic              dmem_wren,
    output logic              select_immed,
    output logic              select_writeval,
    output logic              select_readReg,
    output logic [1:0]        select_pc,
    output logic              j_or_jal,
    output logic              is_setx,
    output logic              take_bex,
    output logic              md_start,
    output logic              md_op,
    output logic              stall,
    output logic              flush,
    output logic              rstatus_wren,
    output logic [WORD_W-1:0] rstatus_val,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WD_LAST    = 8'(MD_TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MD_BUSY = 2'd1,
        S_MD_DONE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic [7:0] wd_q, wd_d;
    logic       md_op_q, md_op_d;
    logic       md_exc_q, md_exc_d;
    logic       post_rst_q, post_rst_d;

    logic is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_bex, is_mul, is_div;
    logic eff_valid, take_bne, take_blt, take_bex_w, take_branch, launch;

    always_comb begin
        is_j    = (opcode == OP_J);
        is_bne  = (opcode == OP_BNE);
        is_jal  = (opcode == OP_JAL);
        is_jr   = (opcode == OP_JR);
        is_addi = (opcode == OP_ADDI);
        is_blt  = (opcode == OP_BLT);
        is_sw   = (opcode == OP_SW);
        is_lw   = (opcode == OP_LW);
        is_bex  = (opcode == OP_BEX);
        is_mul  = (opcode == OP_ALU) && (aluop == ALU_MUL);
        is_div  = (opcode == OP_ALU) && (aluop == ALU_DIV);

        // The cycle right after reset is forced idle so a still-presented instruction cannot relaunch.
        eff_valid   = in_valid && (state_q == S_IDLE) && !post_rst_q;
        take_bne    = eff_valid && is_bne && isNotEqual;
        take_blt    = eff_valid && is_blt && isNotEqual && !isLessThan;
        take_bex_w  = eff_valid && is_bex && isNotEqual;
        take_branch = take_bne || take_blt || take_bex_w;
        launch      = eff_valid && (is_mul || is_div);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned
        // and no latch is inferred.
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        wd_d            = wd_q;
        md_op_d         = md_op_q;
        md_exc_d        = md_exc_q;
        post_rst_d      = reset;

        reg_wren        = 1'b0;
        dmem_wren       = 1'b0;
        select_immed    = 1'b0;
        select_writeval = 1'b0;
        select_readReg  = 1'b0;
        select_pc       = 2'b00;
        j_or_jal        = 1'b0;
        is_setx         = 1'b0;
        take_bex        = 1'b0;
        md_start        = 1'b0;
        md_op           = md_op_q;
        stall           = 1'b0;
        flush           = 1'b0;
        rstatus_wren    = 1'b0;
        rstatus_val     = '0;

        unique case (state_q)
            S_IDLE: begin
                select_immed    = eff_valid && (is_addi || is_sw || is_lw);
                dmem_wren       = eff_valid && is_sw;
                select_writeval = eff_valid && is_lw;
                select_readReg  = eff_valid && (is_sw || is_bne || is_jr || is_blt);
                j_or_jal        = eff_valid && (is_j || is_jal);
                is_setx         = eff_valid && (opcode == OP_SETX);
                take_bex        = take_bex_w;
                select_pc[0]    = take_branch;
                select_pc[1]    = take_bne || take_blt;
                // A mul/div writes its result in MD_DONE, never in its launch cycle.
                reg_wren        = eff_valid && !launch &&
                                  !(is_sw || is_j || is_bne || is_jr || is_blt || is_bex);
                if (launch) begin
                    md_start = 1'b1;
                    md_op    = is_div;
                    md_op_d  = is_div;
                    stall    = 1'b1;
                    wd_d     = '0;
                    md_exc_d = 1'b0;
                    state_d  = S_MD_BUSY;
                end else if (take_branch) begin
                    flush   = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
                end
            end
            S_MD_BUSY: begin
                stall = 1'b1;
                wd_d  = wd_q + 8'd1;
                if (md_ready) begin
                    md_exc_d = md_exception;
                    state_d  = S_MD_DONE;
                end else if (wd_q == WD_LAST) begin
                    md_exc_d = 1'b1;
                    state_d  = S_MD_DONE;
                end
            end
            S_MD_DONE: begin
                if (md_exc_q) begin
                    rstatus_wren = 1'b1;
                    rstatus_val  = md_op_q ? WORD_W'(RSTATUS_DIV) : WORD_W'(RSTATUS_MUL);
                end else begin
                    reg_wren = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                flush  = 1'b1;
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_q <= 4'd1) begin
                    fcnt_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values and simulation order cannot create races.
        post_rst_q <= post_rst_d;
        if (reset) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            wd_q     <= '0;
            md_op_q  <= 1'b0;
            md_exc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            wd_q     <= wd_d;
            md_op_q  <= md_op_d;
            md_exc_q <= md_exc_d;
        end
    end

`ifdef X_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
        if (take_branch && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_d = perf_flush_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/x_ctrl_seq.md
Name: x_ctrl_seq

Overview:
- Next-generation execute-stage control unit for the 5-stage pipeline.
- Decodes opcode/aluop into the datapath selects and resolves bne/blt/bex, like the current X-stage control.
- Adds sequential behaviour the combinational version lacks:
  - stall FSM that sequences the multi-cycle multdiv unit, with a watchdog;
  - parametrised-length flush counter after taken branches;
  - rstatus exception write-back.

Parameters:
- WORD_W, 32, width of rstatus_val.
- FLUSH_CYCLES, 2, cycles of flush after a taken branch (1..15).
- MD_TIMEOUT, 40, max cycles in MD_BUSY before a forced exception (2..255).
- RSTATUS_MUL, 4, rstatus value on mul exception/timeout.
- RSTATUS_DIV, 5, rstatus value on div exception/timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  X-stage holds a real instruction (0 = bubble).
- opcode  in  5  instruction opcode.
- aluop  in  5  ALU op field; used only when opcode = 0.
- isNotEqual  in  1  ALU compare: operands differ.
- isLessThan  in  1  ALU compare: A < B.
- md_ready  in  1  multdiv result valid.
- md_exception  in  1  multdiv error; qualified by md_ready.
- reg_wren, dmem_wren, select_immed, select_writeval, select_readReg  out  1 each  datapath selects.
- select_pc  out  2  00 = pc+1, 01 = bex target, 11 = branch target.
- j_or_jal  out  1  decoded j or jal.
- is_setx  out  1  decoded setx.
- take_bex  out  1  bex taken.
- md_start  out  1  one-cycle multdiv launch.
- md_op  out  1  0 = mul, 1 = div; held stable while busy.
- stall  out  1  freeze PC/F/D/X latches.
- flush  out  1  squash F/D instructions.
- rstatus_wren  out  1  write rstatus_val to r30.
- rstatus_val  out  WORD_W  exception code.
- perf_stall_cnt  out  32  see Optional Feature.
- perf_flush_cnt  out  32  see Optional Feature.

Behaviour:
- Opcode decode: 0 ALU, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw, 21 setx, 22 bex.
- ALU aluop decode: 6 mul, 7 div.
- Combinational decode is gated by eff_valid = in_valid & state==IDLE & !flush.
  - reg_wren = eff_valid & !(sw|j|bne|jr|blt|bex).
  - select_immed = addi|sw|lw.
  - dmem_wren = sw.
  - select_writeval = lw.
  - select_readReg = sw|bne|jr|blt.
- Branch conditions:
  - take_bne = bne & isNotEqual.
  - take_blt = blt & isNotEqual & !isLessThan (operand order rd,rs).
  - take_bex = bex & isNotEqual.
- select_pc[0] = take_bne|take_blt|take_bex; select_pc[1] = take_bne|take_blt. j/jal never drive select_pc.
- FSM states: IDLE, MD_BUSY, MD_DONE, FLUSH.
- IDLE:
  - eff_valid & (mul|div): md_start=1 and md_op latched this cycle, stall=1, next MD_BUSY, watchdog cleared.
  - eff_valid & taken branch: next FLUSH, flush counter loaded with FLUSH_CYCLES-1.
  - Otherwise stay in IDLE.
- MD_BUSY:
  - stall=1; all write enables 0; watchdog increments each cycle.
  - md_ready=1: next MD_DONE; latch md_exception.
  - Watchdog reaches MD_TIMEOUT-1 without md_ready: next MD_DONE with exception forced to 1.
  - md_ready is ignored in every other state, including the md_start cycle.
- MD_DONE (1 cycle):
  - stall=0.
  - No exception: reg_wren=1.
  - Exception: reg_wren=0, rstatus_wren=1, rstatus_val = md_op ? RSTATUS_DIV : RSTATUS_MUL.
  - Next IDLE.
- FLUSH:
  - flush=1 and eff_valid=0 for exactly FLUSH_CYCLES cycles total, counting the redirect cycle.
  - The counter decrements; at 0, next IDLE.
  - No mul/div or branch can launch in FLUSH.
- Reset:
  - State IDLE; counters 0; md_op=0.
  - All outputs 0 (select_pc=00) in the cycle after reset is sampled high.
  - Reset mid-MD_BUSY abandons the operation; md_start is not reissued.
- Simultaneous events: a stalled or flushing instruction never issues; in_valid=0 forces every enable to 0 regardless of opcode.

Optional Feature:
- Macro: X_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle stall=1.
  - perf_flush_cnt increments once per taken branch.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- addi (opcode 5), in_valid=1 -> reg_wren=1, select_immed=1, select_pc=00, stall=0, flush=0.
- bne with isNotEqual=1, FLUSH_CYCLES=2 -> select_pc=11 for 1 cycle; flush=1 for 2 cycles; an addi presented during flush gets reg_wren=0.
- mul (op 0, aluop 6), md_ready after 5 cycles, no exception -> md_start 1 cycle, stall=1 for 6 cycles, then reg_wren=1 for 1 cycle in MD_DONE.
- div, md_ready=1 with md_exception=1 -> rstatus_wren=1, rstatus_val=5, reg_wren=0.
- div, md_ready never asserted, MD_TIMEOUT=40 -> stall for 40 cycles, then rstatus_wren=1, rstatus_val=5; reset asserted mid-busy instead -> all outputs 0 next cycle, no md_start.
- With X_CTRL_PERF_EN defined: after the mul test plus 2 taken branches -> perf_stall_cnt=6, perf_flush_cnt=2.
